// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel/line counters, active-area decode, delayed
// active-low syncs, line/frame boundary pulses and a completed-frame counter.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int PIPE_DELAY = 1
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic        pix_en,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] C_H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] C_V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] C_H_VIS     = 10'(H_VISIBLE);
    localparam logic [9:0] C_V_VIS     = 10'(V_VISIBLE);
    localparam logic [9:0] C_HS_START  = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] C_HS_END    = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] C_VS_START  = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] C_VS_END    = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [9:0]  r_hc;
    logic [9:0]  r_vc;
    logic        r_line_start;
    logic        r_frame_start;
    logic [15:0] r_frame_count;

    logic        w_h_last;
    logic        w_v_last;
    logic        w_hs_raw;
    logic        w_vs_raw;

    assign w_h_last = (r_hc == C_H_LAST);
    assign w_v_last = (r_vc == C_V_LAST);

    // Raw sync levels straight from the counters, active low.
    assign w_hs_raw = !((r_hc >= C_HS_START) && (r_hc < C_HS_END));
    assign w_vs_raw = !((r_vc >= C_VS_START) && (r_vc < C_VS_END));

    assign DrawX       = r_hc;
    assign DrawY       = r_vc;
    assign blank       = (r_hc < C_H_VIS) && (r_vc < C_V_VIS);
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;

    // Scan counters with wrap pulses; pulses self-clear on any edge so they
    // stay one vga_clk wide even when pix_en is sparse.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_hc          <= '0;
            r_vc          <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (pix_en) begin
                if (!w_h_last) begin
                    r_hc <= r_hc + 10'd1;
                end else begin
                    r_hc         <= '0;
                    r_line_start <= 1'b1;
                    if (w_v_last) begin
                        r_vc          <= '0;
                        r_frame_start <= 1'b1;
                        r_frame_count <= r_frame_count + 16'd1;
                    end else begin
                        r_vc <= r_vc + 10'd1;
                    end
                end
            end
        end
    end

    generate
        if (PIPE_DELAY == 0) begin : g_no_delay
            assign hs = w_hs_raw;
            assign vs = w_vs_raw;
        end else begin : g_delay
            logic [PIPE_DELAY-1:0] r_hs_d;
            logic [PIPE_DELAY-1:0] r_vs_d;

            // Sync delay chain, advanced only on enabled pixels so the lag
            // is measured in pixels rather than vga_clk cycles.
            always_ff @(posedge vga_clk) begin
                if (reset) begin
                    r_hs_d <= '1;
                    r_vs_d <= '1;
                end else if (pix_en) begin
                    r_hs_d[0] <= w_hs_raw;
                    r_vs_d[0] <= w_vs_raw;
                    for (int k = 1; k < PIPE_DELAY; k++) begin
                        r_hs_d[k] <= r_hs_d[k-1];
                        r_vs_d[k] <= r_vs_d[k-1];
                    end
                end
            end

            assign hs = r_hs_d[PIPE_DELAY-1];
            assign vs = r_vs_d[PIPE_DELAY-1];
        end
    endgenerate

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Scan-timing source for the VGA pixel path. Produces DrawX, DrawY and blank for the sprite/ROM/palette stages, and the hs/vs sync pins.
- Sync outputs are delayed by a parameterised number of pixel stages. This keeps them aligned with colour that downstream logic registers on vga_clk.
- Also produces line/frame boundary pulses and a frame counter for game-logic frame ticks.

Parameters:
H_VISIBLE 640 visible pixels per line
H_FP 16 horizontal front porch, pixels
H_SYNC 96 horizontal sync width, pixels
H_BP 48 horizontal back porch, pixels
V_VISIBLE 480 visible lines per frame
V_FP 10 vertical front porch, lines
V_SYNC 2 vertical sync width, lines
V_BP 33 vertical back porch, lines
PIPE_DELAY 1 number of pixel stages by which hs/vs lag the counters (0..4)

Ports:
vga_clk input 1 pixel clock; all logic on rising edge
reset input 1 synchronous, active-high
pix_en input 1 pixel advance enable; when 0, counters, delay chain and frame_count hold
DrawX output 10 current horizontal position, 0..H_TOTAL-1
DrawY output 10 current vertical position, 0..V_TOTAL-1
blank output 1 1 = display-active region (DrawX<H_VISIBLE and DrawY<V_VISIBLE); 0 = blanking
hs output 1 horizontal sync, active low, delayed PIPE_DELAY stages
vs output 1 vertical sync, active low, delayed PIPE_DELAY stages
line_start output 1 one-vga_clk pulse after hc wraps to 0
frame_start output 1 one-vga_clk pulse after (hc,vc) wraps to (0,0)
frame_count output 16 completed-frame counter

Behaviour:
- Derived constants:
  - H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525).
  - Both must be ≤1024.
- Registers:
  - hc, vc: 10-bit.
  - Delay chains hs_d[0..PIPE_DELAY-1] and vs_d[0..PIPE_DELAY-1].
  - line_start, frame_start and frame_count are registered.
- Reset (synchronous, dominates pix_en):
  - hc=0, vc=0, all delay stages=1, line_start=0, frame_start=0, frame_count=0.
  - While reset is held: DrawX=0, DrawY=0, blank=1, hs=1, vs=1.
- Counting, on a vga_clk edge with pix_en=1:
  - If hc<H_TOTAL-1: hc<=hc+1.
  - Otherwise hc<=0, and vc advances: vc<=vc+1, or vc<=0 when vc=V_TOTAL-1.
  - With pix_en=0 nothing advances.
- DrawX=hc and DrawY=vc, combinational from the registers.
- blank is combinationally decoded from hc/vc. It is 1 only when hc<H_VISIBLE and vc<V_VISIBLE.
- Raw sync decode:
  - hs_raw=0 iff H_VISIBLE+H_FP ≤ hc < H_VISIBLE+H_FP+H_SYNC, i.e. 656..751.
  - vs_raw=0 iff V_VISIBLE+V_FP ≤ vc < V_VISIBLE+V_FP+V_SYNC, i.e. 490..491.
- Sync delay chain:
  - PIPE_DELAY=0: hs=hs_raw and vs=vs_raw, combinational.
  - PIPE_DELAY≥1: on each pix_en=1 edge, stage0<=raw and stage k<=stage k-1; hs/vs = the last stage.
  - Net effect: the sync edges appear PIPE_DELAY enabled pixels after the counter value that causes them.
- line_start:
  - Set to 1 on the enabled edge where hc wraps from H_TOTAL-1 to 0.
  - Cleared on the next vga_clk edge, whether or not pix_en is high.
  - It is therefore exactly one vga_clk wide, even when pix_en is sparse.
- frame_start: same rule as line_start, but triggered when hc=H_TOTAL-1 and vc=V_TOTAL-1 wrap together. line_start also fires on that edge.
- frame_count increments by 1 (mod 2^16) on the same edge that sets frame_start. 0xFFFF wraps to 0x0000.
- No pulses are generated at reset release: the first frame_start occurs only after a full frame.
- Reset mid-line or mid-frame: counters return to (0,0) on the next edge and delay chains refill with 1s. Any in-flight sync low is discarded. Pending pulses are cleared.
- Sync polarity is fixed active-low (standard 640x480@60).

Test Plan:
- Reset for 3 cycles, then pix_en=1 continuously. DrawX counts 0..799, then wraps to 0 while DrawY goes 0→1. line_start is high for exactly 1 cycle with DrawX=0, DrawY=1.
- Horizontal sync alignment, PIPE_DELAY=1. hs samples low first in the cycle where DrawX=657, and is high again at DrawX=753. Low width is 96 cycles. blank falls at DrawX=640.
- Run a full frame of 420000 enabled cycles:
  - vs is low for exactly 1600 cycles, starting at (DrawX=1, DrawY=490).
  - frame_start pulses once, with DrawX=0, DrawY=0, and frame_count=1 in that cycle.
  - blank=1 for exactly 307200 of the cycles.
- Toggle pix_en 1-0-0-1 repeatedly. Counters advance only on enabled edges; hs/vs delay is counted in enabled pixels. A line wrap during the pattern gives a line_start pulse of exactly one vga_clk.
- Assert reset at DrawX=700, DrawY=490 (hs and vs both low). On the next edge: DrawX=0, DrawY=0, hs=1, vs=1, blank=1, and frame_count=0.
- Preload the counter with frame_count=0xFFFF via a bench force, then complete one frame. frame_count=0x0000 and frame_start pulses.
